audio_capture_ctrl: RTL and testbench

//  Sequences the 4-bank audio sample buffer feeding the spectrogram datapath: owns the write pointer and bank select.

---
 rtl/audio_capture_ctrl_pkg.sv | 31 +++
 rtl/audio_capture_ctrl_trig_det.sv | 48 ++++
 rtl/audio_capture_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_audio_capture_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_capture_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// audio_capture_ctrl_pkg
// Purpose: shared definitions for the audio capture sequencer slice. Holds the
//          capture state encoding, the sample width, the default geometry of
//          the 4-bank sample buffer, and a helper that says whether a state
//          writes incoming samples into the buffer.
// Ports:   none (package)
// -----------------------------------------------------------------------------
package audio_capture_ctrl_pkg;

  localparam int SAMPLE_W         = 18;
  localparam int DEF_ABIT         = 12;
  localparam int DEF_PRE_SAMPLES  = 4096;
  localparam int DEF_POST_SAMPLES = 8192;
  localparam int DEF_RD_OFS       = 402;

  // The encoding is visible on the STATE status port, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_ARMED  = 3'd2,
    ST_POST   = 3'd3,
    ST_FROZEN = 3'd4
  } cap_state_t;

  // RUN, ARMED and POST all stream samples into the buffer.
  function automatic logic is_writing(input cap_state_t s);
    return (s == ST_RUN) || (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/audio_capture_ctrl_trig_det.sv
// -----------------------------------------------------------------------------
// audio_trig_det
// Purpose: rising-edge trigger detector for the capture sequencer. Remembers
//          the previously written sample and flags a sample that crosses the
//          threshold from below, but only once enough pre-trigger history has
//          been captured.
// Ports:
//   clk         in  1         system clock
//   rst         in  1         synchronous reset, active-high (prev_sample -> 0)
//   sample_stb  in  1         a sample is being written this cycle
//   sample      in  SAMPLE_W  signed sample value
//   trig_level  in  SAMPLE_W  signed threshold
//   pre_ok      in  1         pre-trigger history is complete
//   hit         out 1         qualified rising crossing on this sample
// -----------------------------------------------------------------------------
module audio_trig_det
  import audio_capture_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_stb,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                pre_ok,
  output logic                hit
);

  logic [SAMPLE_W-1:0] prev_sample;
  logic                crossing;

  // Only samples that actually land in the buffer become the history used for
  // the crossing test, so idle/frozen strobes never fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sample <= '0;
    end else if (sample_stb) begin
      prev_sample <= sample;
    end
  end

  // Samples are two's complement, so the comparison must be signed.
  always_comb begin
    crossing = ($signed(prev_sample) < $signed(trig_level)) &&
               ($signed(sample) >= $signed(trig_level));
    hit      = sample_stb && crossing && pre_ok;
  end

endmodule

// File: rtl/audio_capture_ctrl.sv
// -----------------------------------------------------------------------------
// audio_capture_ctrl
// Purpose: sequences the 4-bank audio sample buffer feeding the spectrogram
//          datapath. Owns the write pointer (low 2 bits = bank), runs the
//          run/armed/post-trigger/frozen capture modes, and generates the
//          display read address from a frame-latched base so the picture never
//          tears mid-frame.
// Ports:
//   CLK          in  1       system clock
//   RST          in  1       synchronous reset, active-high
//   AUDIO        in  18      signed sample, valid with AUDIORDY
//   AUDIORDY     in  1       one-cycle sample strobe
//   RUN_REQ      in  1       capture enable level
//   TRIG_EN      in  1       1 = triggered capture, 0 = free run
//   TRIG_LEVEL   in  18      signed trigger threshold
//   FRAME_START  in  1       end-of-frame strobe, latches the read base
//   LINE_START   in  1       line read start strobe, reloads RD_ADR
//   WR_EN        out 1       buffer write strobe
//   WR_BANK      out 2       bank select for the write
//   WR_ADR       out ABIT    per-bank write address
//   WR_DATA      out 18      sample to write
//   RD_ADR       out ABIT    per-bank display read address
//   TRIG_POS     out ABIT+2  write pointer of the trigger sample
//   STATE        out 3       current capture state
// -----------------------------------------------------------------------------
module audio_capture_ctrl
  import audio_capture_ctrl_pkg::*;
#(
  parameter int ABIT         = DEF_ABIT,
  parameter int PRE_SAMPLES  = DEF_PRE_SAMPLES,
  parameter int POST_SAMPLES = DEF_POST_SAMPLES,
  parameter int RD_OFS       = DEF_RD_OFS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [SAMPLE_W-1:0] AUDIO,
  input  logic                AUDIORDY,
  input  logic                RUN_REQ,
  input  logic                TRIG_EN,
  input  logic [SAMPLE_W-1:0] TRIG_LEVEL,
  input  logic                FRAME_START,
  input  logic                LINE_START,
  output logic                WR_EN,
  output logic [1:0]          WR_BANK,
  output logic [ABIT-1:0]     WR_ADR,
  output logic [SAMPLE_W-1:0] WR_DATA,
  output logic [ABIT-1:0]     RD_ADR,
  output logic [ABIT+1:0]     TRIG_POS,
  output logic [2:0]          STATE
);

  localparam int PRE_W  = $clog2(PRE_SAMPLES + 1);
  localparam int POST_W = $clog2(POST_SAMPLES + 1);

  localparam logic [PRE_W-1:0]  PRE_MAX    = PRE_W'(PRE_SAMPLES);
  localparam logic [POST_W-1:0] POST_MAX   = POST_W'(POST_SAMPLES);
  localparam logic [POST_W-1:0] POST_LAST  = POST_W'(1);
  localparam logic [ABIT-1:0]   RD_OFS_VAL = ABIT'(RD_OFS);

  cap_state_t          state;
  cap_state_t          state_next;
  logic [ABIT+1:0]     wr_ptr;
  logic [ABIT-1:0]     frame_base;
  logic [PRE_W-1:0]    pre_cnt;
  logic [POST_W-1:0]   post_cnt;
  logic                wr_stb;
  logic                pre_ok;
  logic                det_hit;
  logic                trig_fire;

  // A strobe is written whenever the current state is a writing state, even
  // if the FSM is leaving that state on this same edge: the in-flight sample
  // always lands, and nothing after it does.
  assign wr_stb = AUDIORDY && is_writing(state);
  assign pre_ok = (pre_cnt == PRE_MAX);
  assign STATE  = state;

  audio_trig_det u_trig_det (
    .clk        (CLK),
    .rst        (RST),
    .sample_stb (wr_stb),
    .sample     (AUDIO),
    .trig_level (TRIG_LEVEL),
    .pre_ok     (pre_ok),
    .hit        (det_hit)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Dropping RUN_REQ wins over everything, including a
  // trigger on the same sample, so a stop request can never start a POST.
  always_comb begin
    state_next = state;
    trig_fire  = 1'b0;
    if (!RUN_REQ) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state_next = TRIG_EN ? ST_ARMED : ST_RUN;
        ST_RUN:    if (TRIG_EN) state_next = ST_ARMED;
        ST_ARMED: begin
          if (!TRIG_EN) begin
            state_next = ST_RUN;
          end else if (det_hit) begin
            state_next = ST_POST;
            trig_fire  = 1'b1;
          end
        end
        ST_POST:   if (AUDIORDY && (post_cnt == POST_LAST)) state_next = ST_FROZEN;
        ST_FROZEN: state_next = ST_FROZEN;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Write path: the sample is registered out one cycle after its strobe with
  // the pre-increment pointer, and the pointer advances on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      WR_EN   <= 1'b0;
      WR_BANK <= '0;
      WR_ADR  <= '0;
      WR_DATA <= '0;
      wr_ptr  <= '0;
    end else begin
      WR_EN <= wr_stb;
      if (wr_stb) begin
        WR_DATA <= AUDIO;
        WR_BANK <= wr_ptr[1:0];
        WR_ADR  <= wr_ptr[ABIT+1:2];
        wr_ptr  <= wr_ptr + 1'b1;
      end
    end
  end

  // Trigger bookkeeping. pre_cnt restarts on every entry into ARMED so each
  // arming needs fresh history; the trigger sample itself is not part of the
  // post-trigger count, which only counts the POST writes after it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_cnt  <= '0;
      post_cnt <= '0;
      TRIG_POS <= '0;
    end else begin
      if ((state_next == ST_ARMED) && (state != ST_ARMED)) begin
        pre_cnt <= '0;
      end else if ((state == ST_ARMED) && wr_stb && !pre_ok) begin
        pre_cnt <= pre_cnt + 1'b1;
      end

      if (trig_fire) begin
        post_cnt <= POST_MAX;
        TRIG_POS <= wr_ptr;
      end else if ((state == ST_POST) && wr_stb && (post_cnt != '0)) begin
        post_cnt <= post_cnt - 1'b1;
      end
    end
  end

  // Display read side. frame_base samples the pre-increment pointer, and a
  // line start coincident with a frame start still uses the old base, so a
  // line is always read against the frame it started in.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_base <= '0;
      RD_ADR     <= '0;
    end else begin
      if (FRAME_START) begin
        frame_base <= wr_ptr[ABIT+1:2];
      end
      if (LINE_START) begin
        RD_ADR <= frame_base + RD_OFS_VAL;
      end else begin
        RD_ADR <= RD_ADR + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_audio_capture_ctrl
// Purpose: directed self-checking bench for audio_capture_ctrl with a small
//          pre/post trigger window so trigger behaviour is reachable quickly.
// Ports:   none (top-level bench)
// -----------------------------------------------------------------------------
module tb_audio_capture_ctrl;

  localparam int ABIT = 12;

  logic              CLK;
  logic              RST;
  logic [17:0]       AUDIO;
  logic              AUDIORDY;
  logic              RUN_REQ;
  logic              TRIG_EN;
  logic [17:0]       TRIG_LEVEL;
  logic              FRAME_START;
  logic              LINE_START;
  logic              WR_EN;
  logic [1:0]        WR_BANK;
  logic [ABIT-1:0]   WR_ADR;
  logic [17:0]       WR_DATA;
  logic [ABIT-1:0]   RD_ADR;
  logic [ABIT+1:0]   TRIG_POS;
  logic [2:0]        STATE;

  int tests_run;
  int tests_failed;

  audio_capture_ctrl #(
    .ABIT         (ABIT),
    .PRE_SAMPLES  (4),
    .POST_SAMPLES (2),
    .RD_OFS       (402)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .AUDIO       (AUDIO),
    .AUDIORDY    (AUDIORDY),
    .RUN_REQ     (RUN_REQ),
    .TRIG_EN     (TRIG_EN),
    .TRIG_LEVEL  (TRIG_LEVEL),
    .FRAME_START (FRAME_START),
    .LINE_START  (LINE_START),
    .WR_EN       (WR_EN),
    .WR_BANK     (WR_BANK),
    .WR_ADR      (WR_ADR),
    .WR_DATA     (WR_DATA),
    .RD_ADR      (RD_ADR),
    .TRIG_POS    (TRIG_POS),
    .STATE       (STATE)
  );

  // 10 ns clock period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one clock worth of strobes, then sample outputs 1 ns after the edge.
  task automatic applyStimulus(input logic rdy, input int sample,
                               input logic frame, input logic line);
    AUDIORDY    = rdy;
    AUDIO       = 18'(sample);
    FRAME_START = frame;
    LINE_START  = line;
    @(posedge CLK);
    #1;
    AUDIORDY    = 1'b0;
    FRAME_START = 1'b0;
    LINE_START  = 1'b0;
  endtask

  // One comparison: counts it, and counts/reports a failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Check one buffer write: strobe, bank, address and data.
  task automatic checkWrite(input string tag, input int bank, input int adr, input int data);
    checkOutput({tag, ".wrEn"},   32'(WR_EN),   32'd1);
    checkOutput({tag, ".wrBank"}, 32'(WR_BANK), 32'(bank));
    checkOutput({tag, ".wrAdr"},  32'(WR_ADR),  32'(adr));
    checkOutput({tag, ".wrData"}, 32'(WR_DATA), 32'(18'(data)));
  endtask

  task automatic doReset();
    RST = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    RST = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RST          = 1'b0;
    AUDIO        = '0;
    AUDIORDY     = 1'b0;
    RUN_REQ      = 1'b0;
    TRIG_EN      = 1'b0;
    TRIG_LEVEL   = '0;
    FRAME_START  = 1'b0;
    LINE_START   = 1'b0;

    // Reset state.
    RUN_REQ = 1'b1;
    doReset();
    checkOutput("rst.state",   32'(STATE),    32'd0);
    checkOutput("rst.wrEn",    32'(WR_EN),    32'd0);
    checkOutput("rst.rdAdr",   32'(RD_ADR),   32'd0);
    checkOutput("rst.trigPos", 32'(TRIG_POS), 32'd0);

    // Free run: five samples walk the banks then bump the address.
    TRIG_EN = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("run.state", 32'(STATE), 32'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 10 + i, 1'b0, 1'b0);
      checkWrite($sformatf("run.w%0d", i), i % 4, i / 4, 10 + i);
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("run.idleWrEn", 32'(WR_EN), 32'd0);

    // Armed: first crossing comes with only 3 samples of history.
    doReset();
    TRIG_EN = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("arm.state", 32'(STATE), 32'd2);
    applyStimulus(1'b1, -3, 1'b0, 1'b0);
    applyStimulus(1'b1, -2, 1'b0, 1'b0);
    applyStimulus(1'b1, -1, 1'b0, 1'b0);
    applyStimulus(1'b1,  0, 1'b0, 1'b0);
    checkOutput("arm.earlyCross", 32'(STATE), 32'd2);
    applyStimulus(1'b1, -1, 1'b0, 1'b0);
    applyStimulus(1'b1, -1, 1'b0, 1'b0);
    checkOutput("arm.negNoTrig", 32'(STATE), 32'd2);
    applyStimulus(1'b1,  1, 1'b0, 1'b0);
    checkOutput("trig.state",   32'(STATE),    32'd3);
    checkOutput("trig.trigPos", 32'(TRIG_POS), 32'd6);
    checkWrite("trig.sample", 2, 1, 1);

    // Post-trigger: two more writes, then frozen with no writes.
    applyStimulus(1'b1, 5, 1'b0, 1'b0);
    checkWrite("post.w1", 3, 1, 5);
    checkOutput("post.state1", 32'(STATE), 32'd3);
    applyStimulus(1'b1, 6, 1'b0, 1'b0);
    checkWrite("post.w2", 0, 2, 6);
    checkOutput("post.frozen", 32'(STATE), 32'd4);
    applyStimulus(1'b1, 7, 1'b0, 1'b0);
    checkOutput("frz.wrEn1", 32'(WR_EN), 32'd0);
    applyStimulus(1'b1, 8, 1'b0, 1'b0);
    checkOutput("frz.wrEn2", 32'(WR_EN), 32'd0);
    checkOutput("frz.state", 32'(STATE), 32'd4);

    // Leaving frozen needs RUN_REQ to drop.
    RUN_REQ = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("frz.rearm", 32'(STATE), 32'd0);

    // Stop request on the same sample as a qualifying crossing.
    RUN_REQ = 1'b1;
    doReset();
    TRIG_EN = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, -4 + i, 1'b0, 1'b0);
    RUN_REQ = 1'b0;
    applyStimulus(1'b1, 2, 1'b0, 1'b0);
    checkOutput("stop.state",   32'(STATE),    32'd0);
    checkOutput("stop.trigPos", 32'(TRIG_POS), 32'd0);
    checkWrite("stop.inflight", 0, 1, 2);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("stop.once", 32'(WR_EN), 32'd0);
    applyStimulus(1'b1, 3, 1'b0, 1'b0);
    checkOutput("stop.noMore", 32'(WR_EN), 32'd0);

    // Pointer wrap with a coincident frame start, then line reloads.
    RUN_REQ = 1'b1;
    doReset();
    TRIG_EN = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16383; i++) applyStimulus(1'b1, i & 16'hFFFF, 1'b0, 1'b0);
    checkWrite("wrap.pre", 2, 12'hFFF, 16382);
    applyStimulus(1'b1, 99, 1'b1, 1'b0);
    checkWrite("wrap.last", 3, 12'hFFF, 99);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("line.reload", 32'(RD_ADR), 32'd401);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("line.incr", 32'(RD_ADR), 32'd402);
    applyStimulus(1'b1, 77, 1'b0, 1'b0);
    checkWrite("wrap.first", 0, 0, 77);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    checkOutput("line.oldBase", 32'(RD_ADR), 32'd401);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("line.newBase", 32'(RD_ADR), 32'd402);

    // Reset in the middle of a post-trigger capture.
    doReset();
    TRIG_EN = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, -1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1, 1'b0, 1'b0);
    checkOutput("mid.post", 32'(STATE), 32'd3);
    RST = 1'b1;
    applyStimulus(1'b1, 4, 1'b0, 1'b0);
    RST = 1'b0;
    checkOutput("mid.state",   32'(STATE),    32'd0);
    checkOutput("mid.wrEn",    32'(WR_EN),    32'd0);
    checkOutput("mid.rdAdr",   32'(RD_ADR),   32'd0);
    checkOutput("mid.trigPos", 32'(TRIG_POS), 32'd0);
    TRIG_EN = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 21, 1'b0, 1'b0);
    checkWrite("mid.ptrZero", 0, 0, 21);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
